// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_if
// Brief    : Fetch-lookup and branch-resolve signal bundle for branch_predictor.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] fetch_pc;
    logic              prediction;
    logic [DATA_W-1:0] predicted_pc;
    logic              update_en;
    logic [DATA_W-1:0] update_pc;
    logic              update_taken;
    logic [DATA_W-1:0] update_target;
    logic              update_predicted;
    logic [15:0]       mispredict_count;

    modport master (
        output fetch_pc,
        output update_en,
        output update_pc,
        output update_taken,
        output update_target,
        output update_predicted,
        input  prediction,
        input  predicted_pc,
        input  mispredict_count
    );

    modport slave (
        input  fetch_pc,
        input  update_en,
        input  update_pc,
        input  update_taken,
        input  update_target,
        input  update_predicted,
        output prediction,
        output predicted_pc,
        output mispredict_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped BTB with 2-bit saturating counters; zero-cycle lookup.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int DATA_W  = 64,
    parameter int ENTRIES = 16
) (
    input  wire logic         clk,
    input  wire logic         arst_n,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_W - IDX_W - 2;

    localparam logic [1:0]        c_CTR_RESET = 2'b01;
    localparam logic [1:0]        c_CTR_ALLOC = 2'b10;
    localparam logic [1:0]        c_CTR_MAX   = 2'b11;
    localparam logic [1:0]        c_CTR_MIN   = 2'b00;
    localparam logic [15:0]       c_CNT_MAX   = 16'hFFFF;
    localparam logic [DATA_W-1:0] c_PC_STEP   = DATA_W'(4);

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [DATA_W-1:0] r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [15:0]       r_miss_cnt;

    logic [IDX_W-1:0] w_fidx;
    logic [TAG_W-1:0] w_ftag;
    logic             w_fhit;
    logic             w_fpred;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;

    assign w_fidx  = bus.fetch_pc[IDX_W+1:2];
    assign w_ftag  = bus.fetch_pc[DATA_W-1:IDX_W+2];
    assign w_fhit  = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
    assign w_fpred = w_fhit && r_ctr[w_fidx][1];

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign bus.prediction       = w_fpred;
    assign bus.predicted_pc     = w_fpred ? r_target[w_fidx] : (bus.fetch_pc + c_PC_STEP);
    assign bus.mispredict_count = r_miss_cnt;

    assign w_uidx = bus.update_pc[IDX_W+1:2];
    assign w_utag = bus.update_pc[DATA_W-1:IDX_W+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_CTR_RESET;
            end
            r_miss_cnt <= '0;
        end else if (bus.update_en) begin
            if (w_uhit) begin
                if (bus.update_taken) begin
                    r_target[w_uidx] <= bus.update_target;
                    if (r_ctr[w_uidx] != c_CTR_MAX) begin
                        r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
                    end
                end else if (r_ctr[w_uidx] != c_CTR_MIN) begin
                    r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
                end
            end else if (bus.update_taken) begin
                // Taken miss evicts whatever aliased into this slot.
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= bus.update_target;
                r_ctr[w_uidx]    <= c_CTR_ALLOC;
            end

            if ((bus.update_predicted != bus.update_taken) && (r_miss_cnt != c_CNT_MAX)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end
endmodule
`default_nettype wire
